// File: rtl/wb_cmd_initiator_if.sv
// Signal bundle for the command/response port and the WBs_* Wishbone bus.
// master: the initiator. slave: the command source, response sink and bus responder.
interface wb_cmd_initiator_if;
  logic        cmd_valid;
  logic        cmd_ready;
  logic        cmd_we;
  logic [16:0] cmd_adr;
  logic [3:0]  cmd_byte_stb;
  logic [31:0] cmd_wdat;

  logic        rsp_valid;
  logic        rsp_ready;
  logic        rsp_we;
  logic        rsp_err;
  logic [31:0] rsp_rdat;

  logic [16:0] WBs_ADR;
  logic [3:0]  WBs_BYTE_STB;
  logic [31:0] WBs_WR_DAT;
  logic        WBs_CYC;
  logic        WBs_STB;
  logic        WBs_WE;
  logic        WBs_RD;
  logic [31:0] WBs_RD_DAT;
  logic        WBs_ACK;

  modport master (
    input  cmd_valid, cmd_we, cmd_adr, cmd_byte_stb, cmd_wdat, rsp_ready,
           WBs_RD_DAT, WBs_ACK,
    output cmd_ready, rsp_valid, rsp_we, rsp_err, rsp_rdat,
           WBs_ADR, WBs_BYTE_STB, WBs_WR_DAT, WBs_CYC, WBs_STB, WBs_WE, WBs_RD
  );

  modport slave (
    output cmd_valid, cmd_we, cmd_adr, cmd_byte_stb, cmd_wdat, rsp_ready,
           WBs_RD_DAT, WBs_ACK,
    input  cmd_ready, rsp_valid, rsp_we, rsp_err, rsp_rdat,
           WBs_ADR, WBs_BYTE_STB, WBs_WR_DAT, WBs_CYC, WBs_STB, WBs_WE, WBs_RD
  );
endinterface

// File: rtl/wb_cmd_initiator.sv
// Command-FIFO driven Wishbone initiator: one queued command becomes one WBs_* cycle,
// completing on ACK or on a no-ACK timeout, with the result returned on a valid/ready port.
module wb_cmd_initiator #(
  parameter int DEPTH   = 4,
  parameter int TIMEOUT = 255
) (
  input  logic                   WB_CLK,
  input  logic                   WB_RST_n,
  wb_cmd_initiator_if.master     bus,
  output logic                   busy,
  output logic [$clog2(DEPTH):0] fifo_level
);
  localparam int          AW       = $clog2(DEPTH);
  localparam logic [15:0] TO_LAST  = 16'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);
  localparam logic [AW:0] LVL_FULL = (AW+1)'(DEPTH);

  typedef struct packed {
    logic        we;
    logic [16:0] adr;
    logic [3:0]  stb;
    logic [31:0] wdat;
  } cmd_t;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_BUS  = 2'd1,
    S_RESP = 2'd2
  } state_t;

  state_t      r_state, w_state_nxt;
  cmd_t        r_mem [DEPTH];
  logic [AW-1:0] r_wptr, r_rptr;
  logic [AW:0] r_level;
  cmd_t        w_cmd_in, w_head;
  logic        w_ready, w_push, w_pop, w_done_ack, w_done_to;

  logic [15:0] r_cnt;
  logic [16:0] r_adr;
  logic [3:0]  r_bstb;
  logic [31:0] r_wdat;
  logic        r_cyc, r_we, r_rd;
  logic        r_rsp_valid, r_rsp_we, r_rsp_err;
  logic [31:0] r_rsp_rdat;

  assign w_cmd_in = '{we: bus.cmd_we, adr: bus.cmd_adr, stb: bus.cmd_byte_stb, wdat: bus.cmd_wdat};
  assign w_head   = r_mem[r_rptr];
  assign w_ready  = (r_level < LVL_FULL);
  assign w_push   = bus.cmd_valid & w_ready;

  // ---------------- command FIFO ----------------
  always_ff @(posedge WB_CLK) begin
    if (w_push) r_mem[r_wptr] <= w_cmd_in;
  end

  always_ff @(posedge WB_CLK or negedge WB_RST_n) begin
    if (!WB_RST_n) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_level <= '0;
    end else begin
      if (w_push) r_wptr <= r_wptr + 1'b1;
      if (w_pop)  r_rptr <= r_rptr + 1'b1;
      unique case ({w_push, w_pop})
        2'b10:   r_level <= r_level + 1'b1;
        2'b01:   r_level <= r_level - 1'b1;
        default: r_level <= r_level;
      endcase
    end
  end

  // ---------------- control FSM ----------------
  always_ff @(posedge WB_CLK or negedge WB_RST_n) begin
    if (!WB_RST_n) r_state <= S_IDLE;
    else           r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    w_pop       = 1'b0;
    w_done_ack  = 1'b0;
    w_done_to   = 1'b0;
    unique case (r_state)
      S_IDLE: begin
        if (r_level != '0) begin
          w_pop       = 1'b1;
          w_state_nxt = S_BUS;
        end
      end
      S_BUS: begin
        // ACK takes priority over a timeout landing on the same edge
        if (bus.WBs_ACK) begin
          w_done_ack  = 1'b1;
          w_state_nxt = S_RESP;
        end else if (TIMEOUT != 0 && r_cnt == TO_LAST) begin
          w_done_to   = 1'b1;
          w_state_nxt = S_RESP;
        end
      end
      S_RESP: begin
        if (bus.rsp_ready) w_state_nxt = S_IDLE;
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // ---------------- bus and response registers ----------------
  always_ff @(posedge WB_CLK or negedge WB_RST_n) begin
    if (!WB_RST_n) begin
      r_cnt       <= '0;
      r_adr       <= '0;
      r_bstb      <= '0;
      r_wdat      <= '0;
      r_cyc       <= 1'b0;
      r_we        <= 1'b0;
      r_rd        <= 1'b0;
      r_rsp_valid <= 1'b0;
      r_rsp_we    <= 1'b0;
      r_rsp_err   <= 1'b0;
      r_rsp_rdat  <= '0;
    end else if (w_pop) begin
      r_adr  <= w_head.adr;
      r_bstb <= w_head.stb;
      r_wdat <= w_head.wdat;
      r_cyc  <= 1'b1;
      r_we   <= w_head.we;
      r_rd   <= ~w_head.we;
      r_cnt  <= '0;
    end else if (w_done_ack | w_done_to) begin
      // ADR/BYTE_STB/WR_DAT intentionally keep their last values
      r_cyc       <= 1'b0;
      r_we        <= 1'b0;
      r_rd        <= 1'b0;
      r_rsp_valid <= 1'b1;
      r_rsp_we    <= r_we;
      r_rsp_err   <= w_done_to;
      r_rsp_rdat  <= (w_done_ack && !r_we) ? bus.WBs_RD_DAT : 32'h0;
    end else if (r_state == S_BUS) begin
      r_cnt <= r_cnt + 16'd1;
    end else if (r_state == S_RESP && bus.rsp_ready) begin
      r_rsp_valid <= 1'b0;
    end
  end

  assign bus.cmd_ready    = w_ready;
  assign bus.WBs_ADR      = r_adr;
  assign bus.WBs_BYTE_STB = r_bstb;
  assign bus.WBs_WR_DAT   = r_wdat;
  assign bus.WBs_CYC      = r_cyc;
  assign bus.WBs_STB      = r_cyc;
  assign bus.WBs_WE       = r_we;
  assign bus.WBs_RD       = r_rd;
  assign bus.rsp_valid    = r_rsp_valid;
  assign bus.rsp_we       = r_rsp_we;
  assign bus.rsp_err      = r_rsp_err;
  assign bus.rsp_rdat     = r_rsp_rdat;

  assign busy       = (r_state != S_IDLE) | (r_level != '0);
  assign fifo_level = r_level;
endmodule
